// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// load_store_unit_if : req/gnt/rvalid data-memory port of the load/store unit
// Revision: 1.0
// ============================================================================
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : RV32I load/store execution with lane alignment and timeout
// Revision: 1.0
// ============================================================================
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Load,
  input  logic              Store,
  input  logic              mem_en,
  input  logic [2:0]        fun3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              addr_exc,
  output logic              bus_err,
  load_store_unit_if.master dmem
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      load_data_q, load_data_d;
  logic [2:0]       fun3_q, fun3_d;
  logic             store_q, store_d;
  logic             addr_exc_q, addr_exc_d;
  logic             bus_err_q, bus_err_d;

  logic             illegal, misaligned, timed_out;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      rd_ext, st_wdata;
  logic [3:0]       st_wstrb;

  assign illegal = (Load & Store) | (Store & ~mem_en) | (Load & mem_en)
                 | (Load & ((fun3 == 3'b011) | (fun3 == 3'b110) | (fun3 == 3'b111)))
                 | (Store & (fun3 >= 3'b011));
  assign misaligned = ((fun3[1:0] == 2'b01) & addr[0])
                    | ((fun3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign timed_out  = (cnt_q == CNT_LAST);

  // Lane selection works on the latched address so it is stable for the whole access.
  always_comb begin
    rd_byte  = dmem.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_half  = dmem.dmem_rdata[{addr_q[1], 4'b0000} +: 16];
    rd_ext   = dmem.dmem_rdata;
    st_wdata = wdata_q;
    st_wstrb = 4'b1111;
    unique case (fun3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = dmem.dmem_rdata;
    endcase
    unique case (fun3_q[1:0])
      2'b00: begin
        st_wdata = {4{wdata_q[7:0]}};
        st_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata_q[15:0]}};
        st_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = wdata_q;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    fun3_d          = fun3_q;
    wdata_d         = wdata_q;
    store_d         = store_q;
    load_data_d     = load_data_q;
    addr_exc_d      = 1'b0;
    bus_err_d       = 1'b0;
    stall           = 1'b0;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = 32'd0;
    dmem.dmem_wdata = 32'd0;
    dmem.dmem_wstrb = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (Load | Store) begin
          if (illegal | misaligned) begin
            addr_exc_d = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = S_REQ;
            cnt_d   = '0;
            addr_d  = addr;
            fun3_d  = fun3;
            wdata_d = wdata;
            store_d = Store;
          end
        end
      end
      S_REQ: begin
        stall           = 1'b1;
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = store_q;
        dmem.dmem_addr  = {addr_q[31:2], 2'b00};
        dmem.dmem_wdata = store_q ? st_wdata : 32'd0;
        dmem.dmem_wstrb = store_q ? st_wstrb : 4'd0;
        if (dmem.dmem_gnt) begin
          if (store_q) begin
            state_d = S_DONE;
          end else if (dmem.dmem_rvalid) begin
            load_data_d = rd_ext;
            state_d     = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end else if (timed_out) begin
          bus_err_d   = 1'b1;
          load_data_d = 32'd0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dmem.dmem_rvalid) begin
          load_data_d = rd_ext;
          state_d     = S_DONE;
        end else if (timed_out) begin
          bus_err_d   = 1'b1;
          load_data_d = 32'd0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= 32'd0;
      fun3_q      <= 3'd0;
      wdata_q     <= 32'd0;
      store_q     <= 1'b0;
      load_data_q <= 32'd0;
      addr_exc_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      fun3_q      <= fun3_d;
      wdata_q     <= wdata_d;
      store_q     <= store_d;
      load_data_q <= load_data_d;
      addr_exc_q  <= addr_exc_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = (state_q == S_DONE) & ~store_q;
  assign addr_exc   = addr_exc_q;
  assign bus_err    = bus_err_q;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_load_store_unit : randomized self-checking bench against a transaction model
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Load = 1'b0, Store = 1'b0, mem_en = 1'b0;
  logic [2:0]  fun3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        stall, load_valid, addr_exc, bus_err;
  logic [31:0] load_data;

  load_store_unit_if bus ();

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .Load       (Load),
    .Store      (Store),
    .mem_en     (mem_en),
    .fun3       (fun3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .addr_exc   (addr_exc),
    .bus_err    (bus_err),
    .dmem       (bus.master)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: access legality, lane data and load extension in plain arithmetic.
  function automatic bit is_bad(bit ld, bit st, bit me, logic [2:0] f, logic [31:0] a);
    int sz;
    if (ld && st) return 1'b1;
    if (st && (!me || f > 3'd2)) return 1'b1;
    if (ld && (me || !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))) return 1'b1;
    sz = 1 << f[1:0];
    return (a % 32'(sz)) != 32'd0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f, logic [31:0] a, logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (f)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f, logic [31:0] w);
    case (f)
      3'b000:  return (w & 32'hFF) * 32'h01010101;
      3'b001:  return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_wstrb(logic [2:0] f, logic [31:0] a);
    case (f)
      3'b000:  return 4'(1 << a[1:0]);
      3'b001:  return 4'(3 << (2 * a[1]));
      default: return 4'hF;
    endcase
  endfunction

  // Per-cycle expectations published by the driver, consumed by the compare process.
  logic        chk_on = 1'b0;
  logic        e_stall = 1'b0, e_req = 1'b0, e_we = 1'b0, e_lv = 1'b0, e_exc = 1'b0, e_berr = 1'b0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_ld = 32'd0, exp_ld = 32'd0;
  logic [3:0]  e_wstrb = 4'd0;

  int          n_stall = 0, n_lv = 0, n_exc = 0, n_berr = 0, n_req = 0;
  logic [31:0] seen_addr = 32'd0, seen_wdata = 32'd0;
  logic [3:0]  seen_wstrb = 4'd0;
  logic        seen_we = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("dmem_req", {31'd0, bus.dmem_req}, {31'd0, e_req});
      chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, e_we});
      chk("dmem_wstrb", {28'd0, bus.dmem_wstrb}, {28'd0, e_wstrb});
      chk("load_valid", {31'd0, load_valid}, {31'd0, e_lv});
      chk("addr_exc", {31'd0, addr_exc}, {31'd0, e_exc});
      chk("bus_err", {31'd0, bus_err}, {31'd0, e_berr});
      chk("load_data", load_data, e_ld);
      if (e_req) begin
        chk("dmem_addr", bus.dmem_addr, e_addr);
        if (e_we) chk("dmem_wdata", bus.dmem_wdata, e_wdata);
      end
    end
    if (stall)      n_stall++;
    if (load_valid) n_lv++;
    if (addr_exc)   n_exc++;
    if (bus_err)    n_berr++;
    if (bus.dmem_req) begin
      n_req++;
      seen_addr  = bus.dmem_addr;
      seen_wdata = bus.dmem_wdata;
      seen_wstrb = bus.dmem_wstrb;
      seen_we    = bus.dmem_we;
    end
  end

  // g: REQ cycles before gnt (>=TO means never); r: cycles from gnt to rvalid (0 = same, >TO never).
  task automatic run_txn(input bit ld, input bit st, input bit me, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int g, input int r, input int gap);
    bit bad, legal, to;
    int e, req_last;
    bad   = is_bad(ld, st, me, f, a);
    legal = !bad;
    to    = 1'b0;
    if (bad)              e = 1;
    else if (g >= TO)     begin e = TO + 1; to = 1'b1; end
    else if (st)          e = g + 2;
    else if (r > TO)      begin e = g + 2 + TO; to = 1'b1; end
    else                  e = g + 2 + r;
    req_last = (g < TO) ? 1 + g : TO;
    for (int c = 0; c <= e; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        n_stall = 0; n_lv = 0; n_exc = 0; n_berr = 0; n_req = 0;
      end
      Load   = (c < e) && ld;
      Store  = (c < e) && st;
      mem_en = me;
      fun3   = f;
      addr   = a;
      wdata  = wd;
      bus.dmem_gnt    = legal && (g < TO) && (c == 1 + g);
      bus.dmem_rvalid = legal && ld && (g < TO) && (r <= TO) && (c == 1 + g + r);
      bus.dmem_rdata  = bus.dmem_rvalid ? rd : $urandom;
      e_stall = legal && (c < e);
      e_req   = legal && (c >= 1) && (c <= req_last);
      e_we    = e_req && st;
      e_addr  = {a[31:2], 2'b00};
      e_wdata = model_wdata(f, wd);
      e_wstrb = e_we ? model_wstrb(f, a) : 4'h0;
      e_lv    = legal && ld && !to && (c == e);
      e_exc   = bad && (c == 1);
      e_berr  = to && (c == e);
      if (c == e && e_lv)    exp_ld = model_load(f, a, rd);
      else if (c == e && to) exp_ld = 32'd0;
      e_ld = exp_ld;
    end
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); #1;
      Load = 1'b0;
      Store = 1'b0;
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = ($urandom % 2) == 1;
      bus.dmem_rdata  = $urandom;
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_wstrb = 4'd0;
      e_lv = 1'b0; e_exc = 1'b0; e_berr = 1'b0; e_ld = exp_ld;
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  bit          r_ld, r_st, r_me;
  logic [2:0]  r_f;
  logic [31:0] r_a;
  int          r_g, r_r;

  initial begin
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'd0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_load_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_addr_exc", {31'd0, addr_exc}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("rst_dmem_addr", bus.dmem_addr, 32'd0);
    chk("rst_dmem_wdata", bus.dmem_wdata, 32'd0);
    chk("rst_dmem_wstrb", {28'd0, bus.dmem_wstrb}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    run_txn(0, 1, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 0, 0, 0);
    settle();
    chk("sw_addr", seen_addr, 32'h100);
    chk("sw_wstrb", {28'd0, seen_wstrb}, 32'hF);
    chk("sw_we", {31'd0, seen_we}, 32'd1);
    chk("sw_stall_cycles", n_stall, 2);

    run_txn(0, 1, 1, 3'b000, 32'h103, 32'h000000A5, 32'd0, 0, 0, 0);
    settle();
    chk("sb_wdata", seen_wdata, 32'hA5A5A5A5);
    chk("sb_wstrb", {28'd0, seen_wstrb}, 32'h8);

    run_txn(0, 1, 1, 3'b001, 32'h102, 32'h0000BEEF, 32'd0, 1, 0, 0);
    settle();
    chk("sh_wstrb", {28'd0, seen_wstrb}, 32'hC);
    chk("sh_wdata", seen_wdata, 32'hBEEFBEEF);

    run_txn(1, 0, 0, 3'b000, 32'h102, 32'd0, 32'h12F45678, 0, 1, 0);
    settle();
    chk("lb_data", load_data, 32'hFFFFFFF4);
    chk("lb_stall_cycles", n_stall, 3);
    chk("lb_valid_count", n_lv, 1);
    run_txn(1, 0, 0, 3'b100, 32'h102, 32'd0, 32'h12F45678, 0, 1, 0);
    settle();
    chk("lbu_data", load_data, 32'h000000F4);
    run_txn(1, 0, 0, 3'b001, 32'h102, 32'd0, 32'h12F45678, 0, 1, 0);
    settle();
    chk("lh_data", load_data, 32'h000012F4);
    run_txn(1, 0, 0, 3'b010, 32'h100, 32'd0, 32'h12F45678, 0, 1, 0);
    settle();
    chk("lw_data", load_data, 32'h12F45678);

    run_txn(1, 0, 0, 3'b010, 32'h101, 32'd0, 32'd0, 0, 1, 0);
    settle();
    chk("misal_exc_count", n_exc, 1);
    chk("misal_req_count", n_req, 0);
    chk("misal_stall_count", n_stall, 0);
    run_txn(1, 1, 1, 3'b010, 32'h100, 32'd0, 32'd0, 0, 1, 0);
    settle();
    chk("ldst_exc_count", n_exc, 1);
    chk("ldst_req_count", n_req, 0);

    run_txn(1, 0, 0, 3'b010, 32'h200, 32'd0, 32'hCAFEF00D, 3, 2, 0);
    settle();
    chk("slow_lw_valid_count", n_lv, 1);
    chk("slow_lw_req_cycles", n_req, 4);
    chk("slow_lw_data", load_data, 32'hCAFEF00D);
    run_txn(1, 0, 0, 3'b010, 32'h204, 32'd0, 32'h01234567, 2, 0, 0);
    settle();
    chk("same_cycle_lw_valid_count", n_lv, 1);
    chk("same_cycle_lw_stall", n_stall, 4);

    // Reset while waiting for read data: everything drops at once, late rvalid ignored.
    chk_on = 1'b0;
    @(posedge clk); #1;
    Load = 1'b1; Store = 1'b0; mem_en = 1'b0; fun3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    Load = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("mid_rst_load_valid", {31'd0, load_valid}, 32'd0);
    chk("mid_rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("mid_rst_load_data", load_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 32'hFFFFFFFF;
      @(negedge clk);
      chk("post_rst_load_valid", {31'd0, load_valid}, 32'd0);
      chk("post_rst_load_data", load_data, 32'd0);
    end
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    exp_ld = 32'd0;
    e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_wstrb = 4'd0;
    e_lv = 1'b0; e_exc = 1'b0; e_berr = 1'b0; e_ld = 32'd0;
    chk_on = 1'b1;

    run_txn(1, 0, 0, 3'b010, 32'h400, 32'd0, 32'h55AA55AA, 0, 0, 0);
    run_txn(1, 0, 0, 3'b010, 32'h404, 32'd0, 32'd0, TO + 3, 0, 0);
    settle();
    chk("gnt_timeout_req_cycles", n_req, TO);
    chk("gnt_timeout_berr_count", n_berr, 1);
    chk("gnt_timeout_lv_count", n_lv, 0);
    chk("gnt_timeout_load_data", load_data, 32'd0);
    run_txn(1, 0, 0, 3'b010, 32'h408, 32'd0, 32'd0, 0, TO + 1, 1);
    settle();
    chk("rvalid_timeout_berr_count", n_berr, 1);

    for (int i = 0; i < 300; i++) begin
      r_a = $urandom;
      if ($urandom_range(0, 99) < 80) begin
        r_ld = ($urandom % 2) == 1;
        r_st = !r_ld;
        r_me = r_st;
        if (r_st) r_f = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0:       r_f = 3'd0;
            1:       r_f = 3'd1;
            2:       r_f = 3'd2;
            3:       r_f = 3'd4;
            default: r_f = 3'd5;
          endcase
        end
        r_a = r_a & ~((32'd1 << r_f[1:0]) - 32'd1);
      end else begin
        r_ld = ($urandom % 2) == 1;
        r_st = ($urandom % 2) == 1;
        if (!r_ld && !r_st) r_ld = 1'b1;
        r_me = ($urandom % 2) == 1;
        r_f  = 3'($urandom);
      end
      case ($urandom_range(0, 9))
        0:       r_g = TO - 1;
        1:       r_g = TO + 1;
        default: r_g = int'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 9))
        0:       r_r = TO;
        1:       r_r = TO + 2;
        default: r_r = int'($urandom_range(0, 3));
      endcase
      run_txn(r_ld, r_st, r_me, r_f, r_a, $urandom, $urandom, r_g, r_r, int'($urandom_range(0, 2)));
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
